// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT, RESP} arb_state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Width of a counter that must hold 0..limit, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 1);
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Fetch/data priority choice with an anti-starvation counter for pending fetches.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = cnt_width(STARVE_LIMIT)
) (
  input  logic             i_pend_i,
  input  logic             d_pend_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output logic             grant_valid_o,
  output logic             grant_data_o,
  output logic [CNT_W-1:0] starve_cnt_o
);

  logic at_limit;

  assign at_limit = (starve_cnt_i == CNT_W'(STARVE_LIMIT));

  // Data wins as the older instruction unless the waiting fetch has hit its limit.
  always_comb begin
    grant_valid_o = i_pend_i | d_pend_i;
    grant_data_o  = 1'b0;
    starve_cnt_o  = starve_cnt_i;
    if (d_pend_i && !(i_pend_i && at_limit)) begin
      grant_data_o = 1'b1;
      if (i_pend_i && !at_limit) starve_cnt_o = starve_cnt_i + CNT_W'(1);
    end else if (i_pend_i) begin
      starve_cnt_o = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store requests onto one memory bus,
// returning data with a one-cycle ready pulse and stalling the pipeline meanwhile.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] imem_addr_i,
  input  logic              imem_read_n_i,
  output logic [DATA_W-1:0] imem_data_o,
  output logic              imem_ready_o,
  input  logic              dmem_read_i,
  input  logic              dmem_write_i,
  input  logic [ADDR_W-1:0] dmem_addr_i,
  input  logic [DATA_W-1:0] dmem_wdata_i,
  output logic [DATA_W-1:0] dmem_rdata_o,
  output logic              dmem_ready_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stall_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = cnt_width(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] imem_data_q, imem_data_d;
  logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;
  logic              bus_req_q, bus_req_d;
  logic              imem_ready_q, imem_ready_d;
  logic              dmem_ready_q, dmem_ready_d;
  logic              err_q, err_d;

  logic              i_pend, d_pend;
  logic              grant_valid, grant_data;
  logic [CNT_W-1:0]  starve_cnt_next;

  assign i_pend = ~imem_read_n_i;
  assign d_pend = dmem_read_i | dmem_write_i;

  arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb_pick (
    .i_pend_i      (i_pend),
    .d_pend_i      (d_pend),
    .starve_cnt_i  (starve_cnt_q),
    .grant_valid_o (grant_valid),
    .grant_data_o  (grant_data),
    .starve_cnt_o  (starve_cnt_next)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_valid) state_d = CMD;
      CMD:     if (bus_gnt_i) state_d = we_q ? RESP : RDWAIT;
      RDWAIT:  if (bus_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    bus_req_d    = (state_d == CMD);
    imem_ready_d = (state_d == RESP) && (owner_q == OWN_I);
    dmem_ready_d = (state_d == RESP) && (owner_q == OWN_D);
  end

  always_comb begin
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    imem_data_d  = imem_data_q;
    dmem_rdata_d = dmem_rdata_q;
    err_d        = err_q | (dmem_read_i & dmem_write_i);
    if (state_q == IDLE) begin
      starve_cnt_d = starve_cnt_next;
      if (grant_valid) begin
        owner_d = grant_data ? OWN_D : OWN_I;
        addr_d  = grant_data ? dmem_addr_i : imem_addr_i;
        we_d    = grant_data & dmem_write_i;
        wdata_d = dmem_wdata_i;
      end
    end
    if ((state_q == RDWAIT) && bus_rvalid_i) begin
      if (owner_q == OWN_I) imem_data_d  = bus_rdata_i;
      else                  dmem_rdata_d = bus_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q      <= OWN_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= '0;
      imem_data_q  <= '0;
      dmem_rdata_q <= '0;
      bus_req_q    <= 1'b0;
      imem_ready_q <= 1'b0;
      dmem_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
      imem_data_q  <= imem_data_d;
      dmem_rdata_q <= dmem_rdata_d;
      bus_req_q    <= bus_req_d;
      imem_ready_q <= imem_ready_d;
      dmem_ready_q <= dmem_ready_d;
      err_q        <= err_d;
    end
  end

  assign imem_data_o  = imem_data_q;
  assign imem_ready_o = imem_ready_q;
  assign dmem_rdata_o = dmem_rdata_q;
  assign dmem_ready_o = dmem_ready_q;
  assign bus_req_o    = bus_req_q;
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign err_o        = err_q;
  assign stall_o      = (i_pend & ~imem_ready_q) | (d_pend & ~dmem_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model of
// arbitration, latency, memory contents, stall and error behaviour.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic        imem_read_n_i = 1'b1;
  logic [31:0] imem_data_o;
  logic        imem_ready_o;
  logic        dmem_read_i = 1'b0;
  logic        dmem_write_i = 1'b0;
  logic [31:0] dmem_addr_i = '0;
  logic [31:0] dmem_wdata_i = '0;
  logic [31:0] dmem_rdata_o;
  logic        dmem_ready_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        stall_o;
  logic        err_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_addr_i(imem_addr_i), .imem_read_n_i(imem_read_n_i),
    .imem_data_o(imem_data_o), .imem_ready_o(imem_ready_o),
    .dmem_read_i(dmem_read_i), .dmem_write_i(dmem_write_i),
    .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
    .dmem_rdata_o(dmem_rdata_o), .dmem_ready_o(dmem_ready_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory seen by the bus, and the architectural view the requesters expect.
  logic [31:0] bus_mem [16];
  logic [31:0] ref_mem [16];

  function automatic int unsigned mi(input logic [31:0] a);
    return {28'd0, a[5:2]};
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h100 + ({28'd0, 4'($urandom_range(15))} << 2);
  endfunction

  // Requester agents.
  bit          f_act, f_done;
  logic [31:0] f_addr;
  bit          d_act, d_done, d_rd, d_wr;
  logic [31:0] d_addr, d_wdata;
  // Requests presented in the previous cycle.
  bit          p_f, p_d, p_dwe;
  logic [31:0] p_faddr, p_daddr, p_dwdata;
  // Transaction in flight.
  bit          busy, granted, is_wr, own_d;
  logic [31:0] t_addr, t_wdata;
  int          resp_cyc, rv_cyc, gnt_cyc;
  int          idle_from, starve;
  bit          err_exp;
  // Stimulus knobs (percentages / max delay).
  int f_pct, d_pct, wr_pct, both_pct, gnt_pct, rv_max;
  bit perturb_en;

  task automatic step();
    bit exp_req, f_fin, d_fin, exp_stall;
    @(posedge clk); #1;
    f_fin = 1'b0;
    d_fin = 1'b0;
    // A request seen in an idle cycle becomes a command on the next cycle.
    if (!busy && (cyc - 1 >= idle_from) && (p_f || p_d)) begin
      busy = 1'b1; granted = 1'b0; resp_cyc = -1; rv_cyc = -1;
      if (p_d && !(p_f && starve == LIMIT)) begin
        own_d = 1'b1; t_addr = p_daddr; is_wr = p_dwe; t_wdata = p_dwdata;
        if (p_f && starve < LIMIT) starve++;
      end else begin
        own_d = 1'b0; t_addr = p_faddr; is_wr = 1'b0; t_wdata = '0;
        starve = 0;
      end
    end
    exp_req = busy && !granted;
    chk("bus_req", bus_req_o, exp_req);
    if (exp_req) begin
      chk("bus_addr", bus_addr_o, t_addr);
      chk("bus_we", bus_we_o, is_wr);
      if (is_wr) chk("bus_wdata", bus_wdata_o, t_wdata);
    end
    chk("imem_ready", imem_ready_o, busy && resp_cyc == cyc && !own_d);
    chk("dmem_ready", dmem_ready_o, busy && resp_cyc == cyc && own_d);
    chk("err", err_o, err_exp);
    if (busy && resp_cyc == cyc) begin
      if (own_d) begin
        if (is_wr) ref_mem[mi(t_addr)] = t_wdata;
        else chk("dmem_rdata", dmem_rdata_o, ref_mem[mi(t_addr)]);
        d_fin = 1'b1;
      end else begin
        chk("imem_data", imem_data_o, ref_mem[mi(t_addr)]);
        f_fin = 1'b1;
      end
      busy = 1'b0;
      idle_from = cyc + 1;
    end

    // Bus side: random grant delay, random read latency, stray rvalids.
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
    if (exp_req && $urandom_range(99) < gnt_pct) begin
      bus_gnt_i = 1'b1; granted = 1'b1; gnt_cyc = cyc;
      if (is_wr) begin
        bus_mem[mi(t_addr)] = t_wdata;
        resp_cyc = cyc + 1;
      end else begin
        rv_cyc = cyc + 1 + $urandom_range(rv_max);
      end
    end
    if (busy && granted && !is_wr && resp_cyc < 0) begin
      if (cyc == rv_cyc) begin
        bus_rvalid_i = 1'b1; bus_rdata_i = bus_mem[mi(t_addr)]; resp_cyc = cyc + 1;
      end
    end else if ($urandom_range(3) == 0) begin
      bus_rvalid_i = 1'b1;
    end

    // Requesters drop (or renew) their request the cycle after their pulse.
    if (f_done) f_act = 1'b0;
    if (d_done) d_act = 1'b0;
    f_done = f_fin;
    d_done = d_fin;
    if (!f_act && $urandom_range(99) < f_pct) begin
      f_act = 1'b1; f_addr = rand_addr();
    end
    if (!d_act && $urandom_range(99) < d_pct) begin
      d_act = 1'b1; d_addr = rand_addr(); d_wdata = $urandom;
      if ($urandom_range(99) < both_pct) begin d_rd = 1'b1; d_wr = 1'b1; end
      else if ($urandom_range(99) < wr_pct) begin d_rd = 1'b0; d_wr = 1'b1; end
      else begin d_rd = 1'b1; d_wr = 1'b0; end
    end
    imem_read_n_i = ~f_act;
    imem_addr_i   = (f_act && !(perturb_en && busy && !own_d)) ? f_addr : $urandom;
    dmem_read_i   = d_act && d_rd;
    dmem_write_i  = d_act && d_wr;
    dmem_addr_i   = (d_act && !(perturb_en && busy && own_d)) ? d_addr : $urandom;
    dmem_wdata_i  = (d_act && !(perturb_en && busy && own_d)) ? d_wdata : $urandom;
    if (d_act && d_rd && d_wr) err_exp = 1'b1;
    p_f = f_act; p_faddr = f_addr;
    p_d = d_act; p_daddr = d_addr; p_dwe = d_wr; p_dwdata = d_wdata;
    #1;
    exp_stall = (f_act && !imem_ready_o) || (d_act && !dmem_ready_o);
    chk("stall", stall_o, exp_stall);
  endtask

  task automatic do_reset(input bit late_rv);
    reset_n = 1'b0;
    imem_read_n_i = 1'b1; dmem_read_i = 1'b0; dmem_write_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_imem_ready", imem_ready_o, 1'b0);
    chk("rst_dmem_ready", dmem_ready_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_imem_data", imem_data_o, 32'h0);
    chk("rst_dmem_rdata", dmem_rdata_o, 32'h0);
    reset_n = 1'b1;
    if (late_rv) begin
      bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    end
    busy = 1'b0; granted = 1'b0; idle_from = cyc; starve = 0; err_exp = 1'b0;
    f_act = 1'b0; f_done = 1'b0; d_act = 1'b0; d_done = 1'b0;
    p_f = 1'b0; p_d = 1'b0;
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 16; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[0] = 32'h0050_0093;
    ref_mem[0] = 32'h0050_0093;
    f_pct = 0; d_pct = 0; wr_pct = 50; both_pct = 0; gnt_pct = 100; rv_max = 0;
    perturb_en = 1'b0;
    do_reset(1'b0);

    // Fetch-only at minimum latency.
    f_pct = 100;
    repeat (20) step();
    // Both sides saturated: starvation limit decides ordering.
    d_pct = 100;
    repeat (80) step();
    // Fully random traffic with bus delays and address perturbation.
    f_pct = 40; d_pct = 40; gnt_pct = 50; rv_max = 3; perturb_en = 1'b1;
    repeat (3000) step();

    // Reset while a read waits for rvalid, then a late rvalid.
    f_pct = 0; d_pct = 0; gnt_pct = 100; rv_max = 0; perturb_en = 1'b0;
    repeat (30) step();
    d_pct = 100; wr_pct = 0; rv_max = 6;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (busy && granted && !is_wr && gnt_cyc < cyc && rv_cyc > cyc) found = 1'b1;
    end
    chk("rdwait_reached", found, 1'b1);
    d_pct = 0;
    do_reset(1'b1);
    repeat (10) step();

    // Simultaneous read and write: issued as a write, sticky error.
    d_pct = 100; both_pct = 100; rv_max = 1;
    repeat (6) step();
    both_pct = 0; wr_pct = 50; f_pct = 30;
    repeat (40) step();
    d_pct = 0; f_pct = 0;
    repeat (20) step();
    do_reset(1'b0);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction fetch stage and the memory stage of the pipelined RISC-V core. It serializes fetch and load/store requests onto one request/grant/response bus and returns data with a one-cycle `*_ready_o` pulse. It raises `stall_o` toward the hazard unit while any pipeline request is still outstanding. It sits between the core top level and the memory/bus model.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: number of consecutive data grants allowed while a fetch is pending; after this the fetch is forced through.

Ports:
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `imem_addr_i`, in, ADDR_W: fetch address.
- `imem_read_n_i`, in, 1: 0 = fetch request pending; 1 = no request.
- `imem_data_o`, out, DATA_W: fetched word; valid while `imem_ready_o` is high.
- `imem_ready_o`, out, 1: one-cycle fetch completion pulse.
- `dmem_read_i`, in, 1: load request.
- `dmem_write_i`, in, 1: store request.
- `dmem_addr_i`, in, ADDR_W: data address.
- `dmem_wdata_i`, in, DATA_W: store data.
- `dmem_rdata_o`, out, DATA_W: load data; valid while `dmem_ready_o` is high.
- `dmem_ready_o`, out, 1: one-cycle load/store completion pulse.
- `bus_req_o`, out, 1: command valid.
- `bus_we_o`, out, 1: 1 = write command.
- `bus_addr_o`, out, ADDR_W: command address.
- `bus_wdata_o`, out, DATA_W: write data.
- `bus_gnt_i`, in, 1: command accepted in this cycle.
- `bus_rvalid_i`, in, 1: read data valid.
- `bus_rdata_i`, in, DATA_W: read data.
- `stall_o`, out, 1: pipeline stall request.
- `err_o`, out, 1: sticky error; set when `dmem_read_i` and `dmem_write_i` are both high.

## Operation
- FSM states:
  - IDLE: sample requests and arbitrate.
  - CMD: `bus_req_o` high; hold until `bus_gnt_i`.
  - RDWAIT: wait for `bus_rvalid_i`.
  - RESP: drive the ready pulse for one cycle, then return to IDLE.
- Arbitration in IDLE:
  - Data request beats fetch, because the data access belongs to the older instruction.
  - Exception: if `starve_cnt == STARVE_LIMIT` and a fetch is pending, the fetch wins.
  - `starve_cnt` increments on each data grant made while a fetch is pending, saturates at STARVE_LIMIT, and clears on any fetch grant.
- The granted owner and command are latched on entry to CMD. `bus_addr_o`, `bus_we_o`, `bus_wdata_o` come from these latches and stay stable until grant, independent of input changes.
- Transitions:
  - CMD, write, with `bus_gnt_i` → RESP.
  - CMD, read, with `bus_gnt_i` → RDWAIT.
  - RDWAIT with `bus_rvalid_i` → RESP; `bus_rdata_i` is captured into the owner's data register.
- Requesters hold their request until their ready pulse. They must deassert, or present a new request, in the cycle after the pulse. IDLE re-samples requests after RESP.
- `dmem_read_i` and `dmem_write_i` high together: the request is treated as a write, and `err_o` is set. `err_o` clears only on reset.
- `bus_rvalid_i` outside RDWAIT is ignored.
- `stall_o = (~imem_read_n_i & ~imem_ready_o) | ((dmem_read_i|dmem_write_i) & ~dmem_ready_o)`. This is the only combinational output.
- Reset (at any state, including mid-transaction):
  - Next state IDLE.
  - `bus_req_o`, `*_ready_o`, `err_o` = 0.
  - `starve_cnt` = 0; data registers = 0.
  - A late `bus_rvalid_i` from an aborted read is ignored.

## Timing
- Request seen in IDLE at cycle N → `bus_req_o` high at N+1.
- Write: `bus_gnt_i` at N+1 → `dmem_ready_o` at N+2. Minimum latency 2.
- Read: `bus_gnt_i` at N+1, `bus_rvalid_i` at N+2 → ready pulse and data at N+3. Minimum latency 3.
- Each cycle of grant or rvalid delay adds exactly one cycle of latency.
- Back-to-back throughput: one transaction per 3 cycles (write) or 4 cycles (read), including the IDLE arbitration cycle.
- All outputs other than `stall_o` are registered.

## Structure
- Package `mem_arb_pkg`:
  - State enum (IDLE, CMD, RDWAIT, RESP).
  - Owner enum (OWN_I, OWN_D).
  - Default `STARVE_LIMIT`.
- Sub-module `arb_pick`:
  - Combinational priority plus starvation-counter logic.
  - Inputs: pending requests, `starve_cnt`.
  - Outputs: grant owner, counter next value.
- The FSM and datapath latches live in the top module.

## Test plan
- Fetch only, addr 0x100, gnt at first req cycle, rvalid one cycle later with 0x00500093 → `imem_ready_o` pulse at N+3, `imem_data_o`=0x00500093, `stall_o` high N..N+2, low at N+3.
- Store 0xDEADBEEF @0x2000 and fetch @0x104 raised together → store issued first (`bus_we_o`=1), fetch command issued after the store's RESP and IDLE cycles.
- Fetch held pending while 5 back-to-back loads arrive, STARVE_LIMIT=4 → fetch granted after the 4th load; 5th load granted after the fetch completes.
- `bus_gnt_i` held low 3 cycles with the requester changing `dmem_addr_i` → `bus_addr_o` stays at the latched address; ready arrives 3 cycles later than minimum.
- Reset pulsed while in RDWAIT, then `bus_rvalid_i`=1 one cycle later → no ready pulse, FSM in IDLE, `bus_req_o`=0.
- `dmem_read_i`=`dmem_write_i`=1 → write command issued, `err_o`=1 and stays 1 until reset.
